// File: rtl/int4_mac_pkg.sv
// rtl/int4_mac_pkg.sv - shared widths and types for the int4 dot-product MAC slice
package int4_mac_pkg;
  localparam int N_ELEM = 66;
  localparam int ELEM_W = 4;
  localparam int ACC_W  = 24;
  localparam int VEC_W  = N_ELEM * ELEM_W;
  localparam int PROD_W = 2 * ELEM_W;
  localparam int DOT_W  = 14;

  typedef logic signed [ELEM_W-1:0] int4_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [DOT_W-1:0]  dot_t;
  typedef logic signed [ACC_W-1:0]  psum_t;
endpackage

// File: rtl/int4_dot66.sv
// rtl/int4_dot66.sv - combinational 66-way signed int4 multiply and balanced adder tree
module int4_dot66
  import int4_mac_pkg::*;
(
  input  logic [VEC_W-1:0] a_vec,
  input  logic [VEC_W-1:0] b_vec,
  output dot_t             o_dot
);
  prod_t              w_prod [66];
  logic signed [8:0]  w_l1   [33];
  logic signed [9:0]  w_l2   [17];
  logic signed [10:0] w_l3   [9];
  logic signed [11:0] w_l4   [5];
  logic signed [12:0] w_l5   [3];
  logic signed [13:0] w_l6   [2];

  always_comb begin
    for (int i = 0; i < 66; i++) begin
      w_prod[i] = prod_t'(int4_t'(a_vec[ELEM_W*i +: ELEM_W]))
                * prod_t'(int4_t'(b_vec[ELEM_W*i +: ELEM_W]));
    end
  end

  // Odd-length levels pass their last node through, sign-extended by one bit.
  always_comb begin
    for (int i = 0; i < 33; i++) w_l1[i] = 9'(w_prod[2*i]) + 9'(w_prod[2*i+1]);
    for (int i = 0; i < 16; i++) w_l2[i] = 10'(w_l1[2*i]) + 10'(w_l1[2*i+1]);
    w_l2[16] = 10'(w_l1[32]);
    for (int i = 0; i < 8; i++)  w_l3[i] = 11'(w_l2[2*i]) + 11'(w_l2[2*i+1]);
    w_l3[8] = 11'(w_l2[16]);
    for (int i = 0; i < 4; i++)  w_l4[i] = 12'(w_l3[2*i]) + 12'(w_l3[2*i+1]);
    w_l4[4] = 12'(w_l3[8]);
    for (int i = 0; i < 2; i++)  w_l5[i] = 13'(w_l4[2*i]) + 13'(w_l4[2*i+1]);
    w_l5[2] = 13'(w_l4[4]);
    w_l6[0] = 14'(w_l5[0]) + 14'(w_l5[1]);
    w_l6[1] = 14'(w_l5[2]);
  end

  // The full 66-term sum is bounded to -3696..4224, so the root needs no extra bit.
  assign o_dot = w_l6[0] + w_l6[1];
endmodule

// File: rtl/int4_mac.sv
// rtl/int4_mac.sv - two-stage pipelined int4 dot product plus partial-sum accumulate
module int4_mac
  import int4_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             int4_en,
  input  logic [VEC_W-1:0] a_vec,
  input  logic [VEC_W-1:0] b_vec,
  input  logic [ACC_W-1:0] partial_sum_in,
  output logic [ACC_W-1:0] partial_sum_out
);
  dot_t  w_dot;
  dot_t  r_dot;
  psum_t r_psum;
  logic  r_en;
  psum_t r_out;

  int4_dot66 u_dot (
    .a_vec (a_vec),
    .b_vec (b_vec),
    .o_dot (w_dot)
  );

  // Enable travels with its beat so a mode switch only affects that beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dot  <= '0;
      r_psum <= '0;
      r_en   <= 1'b0;
      r_out  <= '0;
    end else begin
      r_dot  <= w_dot;
      r_psum <= psum_t'(partial_sum_in);
      r_en   <= int4_en;
      r_out  <= r_psum + (r_en ? psum_t'(r_dot) : psum_t'(0));
    end
  end

  assign partial_sum_out = r_out;
endmodule

// File: tb/tb_int4_mac.sv
// tb/tb_int4_mac.sv - directed and random self-checking bench for int4_mac
module tb_int4_mac;
  logic         clk;
  logic         rst_n;
  logic         int4_en;
  logic [263:0] a_vec;
  logic [263:0] b_vec;
  logic [23:0]  partial_sum_in;
  logic [23:0]  partial_sum_out;

  int errors;
  int checks;
  logic [23:0] m_d1;
  logic [23:0] m_out;
  logic [263:0] ones_v, m8_v, p7_v, zero_v, ra, rb, ra2, rb2;

  int4_mac dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .int4_en         (int4_en),
    .a_vec           (a_vec),
    .b_vec           (b_vec),
    .partial_sum_in  (partial_sum_in),
    .partial_sum_out (partial_sum_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [263:0] fill(input logic [3:0] v);
    logic [263:0] r;
    for (int i = 0; i < 66; i++) r[4*i +: 4] = v;
    return r;
  endfunction

  function automatic logic [263:0] rand_vec();
    logic [263:0] r;
    for (int i = 0; i < 66; i++) r[4*i +: 4] = 4'($urandom);
    return r;
  endfunction

  function automatic logic [23:0] ref_dot(input logic [263:0] a, input logic [263:0] b);
    int s;
    int ai;
    int bi;
    s = 0;
    for (int i = 0; i < 66; i++) begin
      ai = int'($signed(a[4*i +: 4]));
      bi = int'($signed(b[4*i +: 4]));
      s += ai * bi;
    end
    return 24'(s);
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One beat: drive at negedge, clock it in, then compare against the reference pipeline.
  task automatic step(input logic rn, input logic en, input logic [263:0] a,
                      input logic [263:0] b, input logic [23:0] ps);
    logic [23:0] beat;
    @(negedge clk);
    rst_n = rn; int4_en = en; a_vec = a; b_vec = b; partial_sum_in = ps;
    beat = ps + (en ? ref_dot(a, b) : 24'd0);
    @(posedge clk);
    m_out = rn ? m_d1 : 24'd0;
    m_d1  = rn ? beat : 24'd0;
    #1;
    chk("model", partial_sum_out, m_out);
  endtask

  initial begin
    errors = 0; checks = 0;
    m_d1 = '0; m_out = '0;
    rst_n = 1'b0; int4_en = 1'b0; a_vec = '0; b_vec = '0; partial_sum_in = '0;
    ones_v = fill(4'd1); m8_v = fill(4'h8); p7_v = fill(4'd7); zero_v = '0;
    ra = rand_vec(); rb = rand_vec(); ra2 = rand_vec(); rb2 = rand_vec();

    step(1'b0, 1'b0, zero_v, zero_v, 24'd0);
    chk("reset_c1", partial_sum_out, 24'd0);
    step(1'b0, 1'b0, zero_v, zero_v, 24'd0);
    chk("reset_c2", partial_sum_out, 24'd0);

    step(1'b1, 1'b1, ones_v, ones_v, 24'd0);
    chk("first_beat_zero", partial_sum_out, 24'd0);
    step(1'b1, 1'b1, m8_v, m8_v, 24'd100);
    chk("ones_66", partial_sum_out, 24'd66);
    step(1'b1, 1'b1, m8_v, p7_v, 24'd0);
    chk("m8m8_plus100", partial_sum_out, 24'h0010E4);
    step(1'b1, 1'b1, ones_v, ones_v, 24'h7FFFFF);
    chk("m8p7_min", partial_sum_out, 24'hFFF190);
    step(1'b1, 1'b0, ra, rb, 24'd12345);
    chk("wrap", partial_sum_out, 24'h800041);
    step(1'b1, 1'b1, ra2, rb2, 24'd0);
    chk("bypass", partial_sum_out, 24'd12345);
    step(1'b1, 1'b1, zero_v, zero_v, 24'd0);
    chk("en_after_bypass", partial_sum_out, ref_dot(ra2, rb2));
    step(1'b1, 1'b1, zero_v, zero_v, 24'd0);
    chk("zeros", partial_sum_out, 24'd0);

    for (int c = 0; c < 1000; c++) begin
      if (c == 500 || c == 501) begin
        step(1'b0, 1'($urandom), rand_vec(), rand_vec(), 24'($urandom));
        chk("midreset", partial_sum_out, 24'd0);
      end else begin
        step(1'b1, ($urandom_range(0, 7) != 0), rand_vec(), rand_vec(), 24'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
